dcache_ctrl: RTL and testbench
==============================

DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 Parameter NUM_LINES, default 32, number of direct-mapped lines; the index is 5 bits wide.
REQ-002 Parameter LINE_BITS, default 256, line width; a line holds 8 x 32-bit words.
REQ-003 Address split SHALL be tag [31:10] (22b), index [9:5], word select [4:2]; bits [1:0] are ignored.
REQ-004 Port clk_i, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port rst_i, input, 1: reset, asynchronous and active-low.
REQ-006 Port cpu_req_i, input, 1: the pipeline memory stage presents a load or store.
REQ-007 Port cpu_we_i, input, 1: 1 means store, 0 means load.
REQ-008 Port cpu_addr_i, input, 32: byte address.
REQ-009 Port cpu_data_i, input, 32: store data.
REQ-010 Port cpu_data_o, output, 32: load data, read by the MEM/WB register.
REQ-011 Port cpu_stall_o, output, 1: freezes the PC and all pipeline registers, including MEM/WB.
REQ-012 Port mem_req_o, output, 1: memory transaction request.
REQ-013 Port mem_we_o, output, 1: 1 means line write-back, 0 means line fetch.
REQ-014 Port mem_addr_o, output, 32: line-aligned address, with bits [4:0] = 0.
REQ-015 Port mem_data_o, output, 256: victim line data.
REQ-016 Port mem_data_i, input, 256: fetched line data.
REQ-017 Port mem_ack_i, input, 1: one-cycle completion pulse from memory.

Function
REQ-018 The cache SHALL be write-back and write-allocate, with one valid bit and one dirty bit per line.
REQ-019 Hit SHALL be defined as cpu_req_i AND valid[index] AND (tag[index] == the full 22-bit address tag).
REQ-020 Load hit: cpu_data_o SHALL present the selected word combinationally in the same cycle, and cpu_stall_o SHALL be 0.
REQ-021 Store hit: the selected word SHALL be written and dirty set at the next edge, with cpu_stall_o = 0.
REQ-022 cpu_stall_o SHALL equal (cpu_req_i AND NOT hit) OR (state != IDLE).
REQ-023 FSM states SHALL be IDLE, WRITEBACK and ALLOCATE.
REQ-024 IDLE: on a miss with the victim valid and dirty, go to WRITEBACK; on a miss otherwise, go to ALLOCATE; on a hit or no request, stay in IDLE.
REQ-025 WRITEBACK: drive mem_req_o=1, mem_we_o=1, mem_addr_o = {victim tag, index, 5'b0} and mem_data_o = victim line; on mem_ack_i, go to ALLOCATE.
REQ-026 ALLOCATE: drive mem_req_o=1, mem_we_o=0 and mem_addr_o = {cpu tag, index, 5'b0}.
REQ-027 ALLOCATE on mem_ack_i: write the line from mem_data_i, set valid=1 and dirty=0, load the tag, and go to IDLE.
REQ-028 After refill, the request SHALL hit in IDLE on the following cycle; a store then merges and sets dirty.
REQ-029 mem_addr_o, mem_we_o and mem_data_o SHALL remain stable while mem_req_o=1.
REQ-030 mem_req_o SHALL be 0 in the cycle after the ack that ends a transaction when returning to IDLE.
REQ-031 From WRITEBACK to ALLOCATE, mem_req_o SHALL drop for exactly one cycle between the two transactions.
REQ-032 mem_ack_i SHALL be ignored while mem_req_o=0.
REQ-033 If cpu_req_i drops mid-miss, the in-flight transaction and refill SHALL still complete, then the FSM returns to IDLE.
REQ-034 Index 0 and index NUM_LINES-1 SHALL behave identically; there is no aliasing between lines.
REQ-035 A store that misses SHALL never write the word before the refill completes.

Reset
REQ-036 On rst_i=0: state = IDLE, all valid and dirty bits = 0, mem_req_o = 0, mem_we_o = 0.
REQ-037 On rst_i=0: cpu_stall_o follows REQ-022 with all lines invalid.
REQ-038 Tag and data arrays SHALL NOT be reset.
REQ-039 Reset asserted mid-transaction SHALL abort it immediately; mem_req_o goes to 0 asynchronously.

Structure
REQ-040 Shared package dcache_pkg SHALL hold TAG_W=22, IDX_W=5, LINE_BITS, WORD_SEL_W=3 and the state enum.
REQ-041 Sub-module dcache_sram SHALL hold the tag, valid, dirty and data arrays, with one read port and one write port.
REQ-042 dcache_sram SHALL support a word-enable write for stores and a full-line write for refills.
REQ-043 dcache_ctrl SHALL contain the FSM, the hit logic and the word mux.

Verification
REQ-044 After reset, load 0x0000_0040 with ack 3 cycles after req -> stall high; one ALLOCATE with mem_addr_o=0x40; cpu_data_o = word 0 of the refill line.
REQ-045 Store 0xDEADBEEF to 0x44 -> hit, no stall, dirty[2]=1; load 0x44 next cycle -> 0xDEADBEEF.
REQ-046 Load 0x0000_0440 (same index 2, new tag) -> WRITEBACK at 0x40 with word 1 = 0xDEADBEEF.
REQ-047 (continuation of REQ-046) -> one cycle with mem_req_o low, then ALLOCATE at 0x440, then hit.
REQ-048 Access 0x3E0 (index 31) then 0x000 (index 0) -> two independent misses, both then hit.
REQ-049 Assert rst_i low during ALLOCATE -> mem_req_o=0 at once; a reload of the same address misses again.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared widths and FSM encoding for the direct-mapped data cache.
package dcache_pkg;

    localparam int ADDR_W     = 32;
    localparam int TAG_W      = 22;
    localparam int IDX_W      = 5;
    localparam int WORD_SEL_W = 3;
    localparam int OFFS_W     = 5;
    localparam int WORD_W     = 32;
    localparam int LINE_BITS  = 256;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage: one combinational read port, one write port
// that either merges a single word (store hit) or replaces a whole line (refill).
module dcache_sram
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 32,
    parameter int LINE_BITS = dcache_pkg::LINE_BITS
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [TAG_W-1:0]      rd_tag,
    output logic                  rd_valid,
    output logic                  rd_dirty,
    output logic [LINE_BITS-1:0]  rd_line,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic                  word_we,
    input  logic [WORD_SEL_W-1:0] word_sel,
    input  logic [WORD_W-1:0]     word_data,
    input  logic                  line_we,
    input  logic [LINE_BITS-1:0]  line_data,
    input  logic [TAG_W-1:0]      line_tag
);

    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_BITS-1:0] data_q [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;

    assign rd_tag   = tag_q[rd_idx];
    assign rd_line  = data_q[rd_idx];
    assign rd_valid = valid_q[rd_idx];
    assign rd_dirty = dirty_q[rd_idx];

    // Line state bits: cleared by reset, refill makes a line valid and clean, store makes it dirty.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (line_we) begin
            valid_q[wr_idx] <= 1'b1;
            dirty_q[wr_idx] <= 1'b0;
        end else if (word_we) begin
            dirty_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; contents are meaningless until valid is set.
    always_ff @(posedge clk_i) begin
        if (line_we) begin
            data_q[wr_idx] <= line_data;
            tag_q[wr_idx]  <= line_tag;
        end else if (word_we) begin
            data_q[wr_idx][word_sel*WORD_W +: WORD_W] <= word_data;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Write-back, write-allocate direct-mapped data cache controller: hit logic,
// load word mux and the IDLE/WRITEBACK/ALLOCATE miss FSM.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 32,
    parameter int LINE_BITS = dcache_pkg::LINE_BITS
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cpu_req_i,
    input  logic                 cpu_we_i,
    input  logic [31:0]          cpu_addr_i,
    input  logic [31:0]          cpu_data_i,
    output logic [31:0]          cpu_data_o,
    output logic                 cpu_stall_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [31:0]          mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i
);

    state_t state_q, state_d;
    logic   alloc_gap_q, alloc_gap_d;
    logic   miss_capture;
    logic   line_we;
    logic   word_we;
    logic   hit;

    logic [ADDR_W-OFFS_W-1:0] miss_line_q;

    logic [TAG_W-1:0]      cpu_tag, miss_tag, rd_tag;
    logic [IDX_W-1:0]      cpu_idx, miss_idx, line_idx;
    logic [WORD_SEL_W-1:0] cpu_wsel;
    logic                  rd_valid, rd_dirty;
    logic [LINE_BITS-1:0]  rd_line;
    logic                  unused_byte_offs;

    assign cpu_tag  = cpu_addr_i[31:10];
    assign cpu_idx  = cpu_addr_i[9:5];
    assign cpu_wsel = cpu_addr_i[4:2];
    assign miss_tag = miss_line_q[26:5];
    assign miss_idx = miss_line_q[4:0];
    assign unused_byte_offs = ^cpu_addr_i[1:0];

    // While a miss is outstanding the array port follows the latched miss line,
    // so the victim and refill address stay put even if the CPU lets go.
    assign line_idx = (state_q == IDLE) ? cpu_idx : miss_idx;

    assign hit         = cpu_req_i & rd_valid & (rd_tag == cpu_tag);
    assign cpu_data_o  = rd_line[cpu_wsel*WORD_W +: WORD_W];
    assign cpu_stall_o = (cpu_req_i & ~hit) | (state_q != IDLE);
    assign word_we     = (state_q == IDLE) & hit & cpu_we_i;
    assign mem_data_o  = rd_line;

    dcache_sram #(
        .NUM_LINES (NUM_LINES),
        .LINE_BITS (LINE_BITS)
    ) u_sram (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .rd_idx    (line_idx),
        .rd_tag    (rd_tag),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_line   (rd_line),
        .wr_idx    (line_idx),
        .word_we   (word_we),
        .word_sel  (cpu_wsel),
        .word_data (cpu_data_i),
        .line_we   (line_we),
        .line_data (mem_data_i),
        .line_tag  (miss_tag)
    );

    // FSM state and the one-cycle request gap between write-back and refill.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            alloc_gap_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            alloc_gap_q <= alloc_gap_d;
        end
    end

    // Latch the missing line address so the whole miss sequence is self-contained.
    always_ff @(posedge clk_i) begin
        if (miss_capture) begin
            miss_line_q <= cpu_addr_i[31:5];
        end
    end

    // Next-state and memory-side outputs; acks count only while mem_req_o is high.
    always_comb begin
        state_d      = state_q;
        alloc_gap_d  = 1'b0;
        miss_capture = 1'b0;
        line_we      = 1'b0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = '0;
        case (state_q)
            IDLE: begin
                if (cpu_req_i && !hit) begin
                    miss_capture = 1'b1;
                    state_d      = (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                mem_req_o  = 1'b1;
                mem_we_o   = 1'b1;
                mem_addr_o = {rd_tag, miss_idx, 5'b0};
                if (mem_ack_i) begin
                    state_d     = ALLOCATE;
                    alloc_gap_d = 1'b1;
                end
            end
            ALLOCATE: begin
                mem_addr_o = {miss_tag, miss_idx, 5'b0};
                if (!alloc_gap_q) begin
                    mem_req_o = 1'b1;
                    if (mem_ack_i) begin
                        line_we = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a hand-driven memory that acks 3 cycles after request.
module tb_dcache_ctrl;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         cpu_req_i = 1'b0;
    logic         cpu_we_i = 1'b0;
    logic [31:0]  cpu_addr_i = '0;
    logic [31:0]  cpu_data_i = '0;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i = '0;
    logic         mem_ack_i = 1'b0;

    int total = 0;
    int bad   = 0;

    dcache_ctrl dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cpu_req_i   (cpu_req_i),
        .cpu_we_i    (cpu_we_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_data_i  (cpu_data_i),
        .cpu_data_o  (cpu_data_o),
        .cpu_stall_o (cpu_stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_data_i  (mem_data_i),
        .mem_ack_i   (mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1);
    end

    function automatic logic [255:0] mkline(input logic [31:0] base);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + i;
        return l;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_i);
    endtask

    // Wait for a request, check it stays stable for 3 cycles, then ack with 'line'.
    task automatic serve(input string tag, input logic exp_we, input logic [31:0] exp_addr,
                         input logic [255:0] line, output logic [255:0] wb, output int waited);
        waited = 0;
        while (!mem_req_o && waited < 20) begin
            step();
            mem_ack_i = 1'b0;
            #1;
            waited++;
        end
        chk({tag, "_req"}, mem_req_o, 1'b1);
        chk({tag, "_we"}, mem_we_o, exp_we);
        chk({tag, "_addr"}, mem_addr_o, exp_addr);
        wb = mem_data_o;
        for (int k = 0; k < 2; k++) begin
            step();
            #1;
            chk({tag, "_hold_req"}, mem_req_o, 1'b1);
            chk({tag, "_hold_addr"}, mem_addr_o, exp_addr);
            chk({tag, "_hold_we"}, mem_we_o, exp_we);
            chk({tag, "_hold_stall"}, cpu_stall_o, 1'b1);
            if (exp_we) chk({tag, "_hold_data"}, mem_data_o, wb);
        end
        step();
        mem_ack_i  = 1'b1;
        mem_data_i = line;
        #1;
        chk({tag, "_ack_stall"}, cpu_stall_o, 1'b1);
        step();
        mem_ack_i  = 1'b0;
        mem_data_i = ~line;
        #1;
    endtask

    logic [255:0] line_a, line_b, line_c, line_d, line_e, wb, exp_wb;
    int waited;

    initial begin
        line_a = mkline(32'hA0A0_0000);
        line_b = mkline(32'hB0B0_0000);
        line_c = mkline(32'hC0C0_0000);
        line_d = mkline(32'hD0D0_0000);
        line_e = mkline(32'hE0E0_0000);

        // reset with a pending request: all lines invalid so it stalls
        cpu_req_i  = 1'b1;
        cpu_addr_i = 32'h40;
        #2 rst_i = 1'b0;
        #1;
        chk("rst_mem_req", mem_req_o, 1'b0);
        chk("rst_mem_we", mem_we_o, 1'b0);
        chk("rst_stall_req", cpu_stall_o, 1'b1);
        cpu_req_i = 1'b0;
        #1;
        chk("rst_stall_idle", cpu_stall_o, 1'b0);
        step();
        rst_i = 1'b1;
        #1;
        chk("post_rst_req", mem_req_o, 1'b0);

        // stray ack with no request is ignored
        step();
        mem_ack_i = 1'b1;
        #1;
        step();
        mem_ack_i = 1'b0;
        #1;
        chk("stray_ack_req", mem_req_o, 1'b0);
        chk("stray_ack_stall", cpu_stall_o, 1'b0);

        // load miss 0x40 -> allocate, then hit with word 0
        step();
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h40;
        #1;
        chk("ld40_miss_stall", cpu_stall_o, 1'b1);
        chk("ld40_idle_req", mem_req_o, 1'b0);
        serve("alloc40", 1'b0, 32'h40, line_a, wb, waited);
        chk("alloc40_latency", waited, 1);
        chk("ld40_hit_stall", cpu_stall_o, 1'b0);
        chk("ld40_req_drop", mem_req_o, 1'b0);
        chk("ld40_data", cpu_data_o, line_a[31:0]);

        // store hit 0x44
        step();
        cpu_we_i = 1'b1; cpu_addr_i = 32'h44; cpu_data_i = 32'hDEADBEEF;
        #1;
        chk("st44_stall", cpu_stall_o, 1'b0);
        chk("st44_mem_req", mem_req_o, 1'b0);
        step();
        cpu_we_i = 1'b0;
        #1;
        chk("st44_dirty2", dut.u_sram.dirty_q[2], 1'b1);
        chk("ld44_data", cpu_data_o, 32'hDEADBEEF);
        chk("ld44_stall", cpu_stall_o, 1'b0);

        // conflict miss 0x440: write-back at 0x40, one-cycle gap, allocate 0x440
        step();
        cpu_addr_i = 32'h440;
        #1;
        chk("ld440_stall", cpu_stall_o, 1'b1);
        exp_wb = line_a;
        exp_wb[63:32] = 32'hDEADBEEF;
        serve("wb40", 1'b1, 32'h40, '0, wb, waited);
        chk("wb40_data", wb, exp_wb);
        chk("gap_req", mem_req_o, 1'b0);
        chk("gap_stall", cpu_stall_o, 1'b1);
        mem_ack_i  = 1'b1;
        mem_data_i = '1;
        serve("alloc440", 1'b0, 32'h440, line_b, wb, waited);
        chk("gap_len", waited, 1);
        chk("ld440_hit_stall", cpu_stall_o, 1'b0);
        chk("ld440_data", cpu_data_o, line_b[31:0]);

        // store miss at index 31: refill first, then the store merges
        step();
        cpu_we_i = 1'b1; cpu_addr_i = 32'h3E4; cpu_data_i = 32'h12345678;
        #1;
        chk("st3e4_stall", cpu_stall_o, 1'b1);
        serve("alloc3e0", 1'b0, 32'h3E0, line_c, wb, waited);
        chk("st3e4_hit_stall", cpu_stall_o, 1'b0);
        chk("st3e4_prestore", cpu_data_o, line_c[63:32]);
        step();
        cpu_we_i = 1'b0;
        #1;
        chk("ld3e4_data", cpu_data_o, 32'h12345678);
        chk("dirty31", dut.u_sram.dirty_q[31], 1'b1);

        // index 0 miss with the CPU request dropping mid-miss
        step();
        cpu_addr_i = 32'h0;
        #1;
        chk("ld0_stall", cpu_stall_o, 1'b1);
        step();
        cpu_req_i = 1'b0; cpu_addr_i = 32'h5555_5554;
        #1;
        chk("ld0_drop_req", mem_req_o, 1'b1);
        chk("ld0_drop_addr", mem_addr_o, 32'h0);
        serve("alloc0", 1'b0, 32'h0, line_d, wb, waited);
        chk("ld0_done_stall", cpu_stall_o, 1'b0);
        chk("ld0_done_req", mem_req_o, 1'b0);
        step();
        cpu_req_i = 1'b1; cpu_addr_i = 32'h0;
        #1;
        chk("ld0_hit_stall", cpu_stall_o, 1'b0);
        chk("ld0_data", cpu_data_o, line_d[31:0]);
        chk("dirty0", dut.u_sram.dirty_q[0], 1'b0);
        step();
        cpu_addr_i = 32'h3E4;
        #1;
        chk("ld3e4_again_stall", cpu_stall_o, 1'b0);
        chk("ld3e4_again_data", cpu_data_o, 32'h12345678);
        step();
        cpu_addr_i = 32'h440;
        #1;
        chk("ld440_again_data", cpu_data_o, line_b[31:0]);

        // reset during allocate aborts at once; same address misses again afterwards
        step();
        cpu_addr_i = 32'h840;
        #1;
        chk("ld840_stall", cpu_stall_o, 1'b1);
        step();
        #1;
        chk("ld840_req", mem_req_o, 1'b1);
        chk("ld840_addr", mem_addr_o, 32'h840);
        #2 rst_i = 1'b0;
        #1;
        chk("midrst_req", mem_req_o, 1'b0);
        chk("midrst_we", mem_we_o, 1'b0);
        chk("midrst_stall", cpu_stall_o, 1'b1);
        step();
        rst_i = 1'b1;
        #1;
        chk("postrst_stall", cpu_stall_o, 1'b1);
        chk("postrst_req", mem_req_o, 1'b0);
        serve("realloc840", 1'b0, 32'h840, line_e, wb, waited);
        chk("realloc840_latency", waited, 1);
        chk("ld840_hit_stall", cpu_stall_o, 1'b0);
        chk("ld840_data", cpu_data_o, line_e[31:0]);
        step();
        cpu_addr_i = 32'h3E4;
        #1;
        chk("ld3e4_postrst_stall", cpu_stall_o, 1'b1);
        serve("realloc3e0", 1'b0, 32'h3E0, line_c, wb, waited);
        chk("ld3e4_postrst_data", cpu_data_o, line_c[63:32]);
        step();
        cpu_req_i = 1'b0;
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
